// File: rtl/wand_bus_pkg.sv
// Shared types and constants for the wired-AND bus scheduler.
package wand_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int unsigned MAX_HOLD_DEF = 8;

  // Wand-neutral level: w ones, right-justified.
  function automatic logic [63:0] idle_val(input int unsigned w);
    if (w >= 64) idle_val = '1;
    else         idle_val = (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/wand_bus_sched_rr_pick.sv
// Rotate-priority picker: first set request at or after i_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [PW-1:0]   o_idx
);

  logic          w_found;
  logic [PW-1:0] w_pos;

  always_comb begin
    o_any   = |i_req;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_pos = PW'((32'(i_ptr) + i) % NREQ);
      if (!w_found && i_req[w_pos]) begin
        o_idx   = w_pos;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wand_bus_sched.sv
// Round-robin owner scheduler for a shared wired-AND bus with bounded tenure
// and a one-cycle turnaround between owners.
module wand_bus_sched
  import wand_bus_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 3,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][W-1:0]      req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             gnt,
  output logic [W-1:0]                bus_drv,
  output logic                        bus_vld,
  output logic                        busy,
  output logic [$clog2(MAX_HOLD)-1:0] hold_cnt,
  output logic                        timeout
);

  localparam int unsigned   PW       = $clog2(NREQ);
  localparam int unsigned   HW       = $clog2(MAX_HOLD);
  localparam logic [W-1:0]  IDLE_BUS = W'(idle_val(W));

  state_e          r_state,  w_state_nx;
  logic [NREQ-1:0] r_gnt,    w_gnt_nx;
  logic [PW-1:0]   r_owner,  w_owner_nx;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nx;
  logic [HW-1:0]   r_hold,   w_hold_nx;
  logic            r_timeout, w_timeout_nx;

  logic            w_any;
  logic [PW-1:0]   w_idx;
  logic            w_end_norm, w_end_wd, w_end_force;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_end_norm  = req[r_owner] && req_last[r_owner];
  assign w_end_wd    = !req[r_owner];
  assign w_end_force = (r_hold == HW'(MAX_HOLD - 1));

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_owner_nx   = r_owner;
    w_rr_ptr_nx  = r_rr_ptr;
    w_hold_nx    = '0;
    w_timeout_nx = 1'b0;
    case (r_state)
      GRANT: begin
        if (w_end_norm || w_end_wd || w_end_force) begin
          w_state_nx   = RELEASE;
          w_gnt_nx     = '0;
          w_rr_ptr_nx  = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
          // Forced release is only flagged when the owner did not end it anyway.
          w_timeout_nx = w_end_force && !w_end_norm && !w_end_wd;
        end else begin
          w_hold_nx = r_hold + HW'(1);
        end
      end
      IDLE, RELEASE: begin
        if (w_any) begin
          w_state_nx      = GRANT;
          w_gnt_nx        = '0;
          w_gnt_nx[w_idx] = 1'b1;
          w_owner_nx      = w_idx;
        end else begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_owner   <= w_owner_nx;
      r_rr_ptr  <= w_rr_ptr_nx;
      r_hold    <= w_hold_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign gnt      = r_gnt;
  assign bus_vld  = (r_state == GRANT);
  assign bus_drv  = (r_state == GRANT) ? req_data[r_owner] : IDLE_BUS;
  assign busy     = (r_state != IDLE);
  assign hold_cnt = r_hold;
  assign timeout  = r_timeout;

endmodule
